// File: rtl/time_param_pkg.sv
// Shared selector codes, FSM encoding and default timing values
// for the alarm timing-parameter store.
package time_param_pkg;

  localparam logic [1:0] SEL_ARM       = 2'd0;
  localparam logic [1:0] SEL_DRIVER    = 2'd1;
  localparam logic [1:0] SEL_PASSENGER = 2'd2;
  localparam logic [1:0] SEL_ALARM     = 2'd3;

  localparam int DEFAULT_W         = 4;
  localparam int DEFAULT_ARM       = 6;
  localparam int DEFAULT_DRIVER    = 8;
  localparam int DEFAULT_PASSENGER = 14;
  localparam int DEFAULT_ALARM     = 10;
  localparam int DEFAULT_HOLD      = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_WRITE   = 3'd2,
    S_ERR     = 3'd3,
    S_HOLD    = 3'd4,
    S_RESTORE = 3'd5
  } state_t;

endpackage

// File: rtl/time_param_store.sv
// Alarm timing-parameter register file with reprogram handshake.
// Optional TIME_PARAM_LOCK_EN blocks writes/restores while armed.
module time_param_store
  import time_param_pkg::*;
#(
  parameter int W             = DEFAULT_W,
  parameter int DEF_ARM       = DEFAULT_ARM,
  parameter int DEF_DRIVER    = DEFAULT_DRIVER,
  parameter int DEF_PASSENGER = DEFAULT_PASSENGER,
  parameter int DEF_ALARM     = DEFAULT_ALARM,
  parameter int HOLD_CYCLES   = DEFAULT_HOLD
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [1:0]   prog_sel,
  input  logic [W-1:0] prog_value,
  input  logic         reprogram,
  input  logic         armed,
  input  logic [1:0]   rd_sel,
  output logic [W-1:0] rd_value,
  output logic         prog_ack,
  output logic         prog_err,
  output logic         restored
);

  localparam int CW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  state_t         r_state;
  state_t         w_next;
  logic           r_q;
  logic [1:0]     r_cap_sel;
  logic [W-1:0]   r_cap_val;
  logic [CW-1:0]  r_hold_cnt;
  logic [W-1:0]   r_params [4];
  logic           w_rise;
  logic           w_lock;

`ifdef TIME_PARAM_LOCK_EN
  assign w_lock = armed;
`else
  logic w_unused_armed;
  assign w_unused_armed = armed;
  assign w_lock = 1'b0;
`endif

  assign w_rise   = reprogram & ~r_q;
  assign rd_value = r_params[rd_sel];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    prog_ack = 1'b0;
    prog_err = 1'b0;
    restored = 1'b0;
    unique case (r_state)
      S_IDLE:    if (w_rise) w_next = S_CHECK;
      S_CHECK: begin
        if (r_cap_val == '0 || w_lock) w_next = S_ERR;
        else                           w_next = S_WRITE;
      end
      S_WRITE: begin
        prog_ack = 1'b1;
        w_next   = S_HOLD;
      end
      S_ERR: begin
        prog_err = 1'b1;
        w_next   = S_HOLD;
      end
      S_HOLD: begin
        if (!reprogram)
          w_next = S_IDLE;
        else if (r_hold_cnt == CNT_LAST && !w_lock)
          w_next = S_RESTORE;
      end
      S_RESTORE: begin
        restored = 1'b1;
        w_next   = S_HOLD;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q         <= 1'b0;
      r_cap_sel   <= SEL_ARM;
      r_cap_val   <= '0;
      r_hold_cnt  <= '0;
      r_params[0] <= W'(DEF_ARM);
      r_params[1] <= W'(DEF_DRIVER);
      r_params[2] <= W'(DEF_PASSENGER);
      r_params[3] <= W'(DEF_ALARM);
    end else begin
      r_q <= reprogram;
      if (r_state == S_IDLE && w_rise) begin
        r_cap_sel <= prog_sel;
        r_cap_val <= prog_value;
      end
      case (r_state)
        S_WRITE: begin
          r_params[r_cap_sel] <= r_cap_val;
          r_hold_cnt          <= '0;
        end
        S_ERR:   r_hold_cnt <= '0;
        S_RESTORE: begin
          r_params[0] <= W'(DEF_ARM);
          r_params[1] <= W'(DEF_DRIVER);
          r_params[2] <= W'(DEF_PASSENGER);
          r_params[3] <= W'(DEF_ALARM);
          r_hold_cnt  <= '0;
        end
        // saturating count so a locked hold never wraps into a restore
        S_HOLD: begin
          if (reprogram && r_hold_cnt != '1)
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
